// File: rtl/ahb_master_mux_pipelined.sv
// AHB-Lite master-to-slave mux: address/control follow the current grant,
// write data follows the registered data-phase owner.
module ahb_master_mux_pipelined #(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                          Hclk,
  input  logic                          Hreset,
  input  logic [MW-1:0]                 Hmaster,
  input  logic                          Hready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] Haddr_M,
  input  logic [NUM_MASTERS*2-1:0]      Htrans_M,
  input  logic [NUM_MASTERS-1:0]        Hwrite_M,
  input  logic [NUM_MASTERS*3-1:0]      Hsize_M,
  input  logic [NUM_MASTERS*3-1:0]      Hburst_M,
  input  logic [NUM_MASTERS*4-1:0]      Hprot_M,
  input  logic [NUM_MASTERS-1:0]        Hmastlock_M,
  input  logic [NUM_MASTERS*DATA_W-1:0] Hwdata_M,
  output logic [ADDR_W-1:0]             Haddr,
  output logic [1:0]                    Htrans,
  output logic                          Hwrite,
  output logic [2:0]                    Hsize,
  output logic [2:0]                    Hburst,
  output logic [3:0]                    Hprot,
  output logic                          Hmastlock,
  output logic [DATA_W-1:0]             Hwdata,
  output logic [MW-1:0]                 Hmaster_data,
  output logic                          Hdata_active
);

  logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
  logic [1:0]        trans_a [NUM_MASTERS];
  logic [2:0]        size_a  [NUM_MASTERS];
  logic [2:0]        burst_a [NUM_MASTERS];
  logic [3:0]        prot_a  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = Haddr_M[i*ADDR_W +: ADDR_W];
    assign trans_a[i] = Htrans_M[i*2 +: 2];
    assign size_a[i]  = Hsize_M[i*3 +: 3];
    assign burst_a[i] = Hburst_M[i*3 +: 3];
    assign prot_a[i]  = Hprot_M[i*4 +: 4];
    assign wdata_a[i] = Hwdata_M[i*DATA_W +: DATA_W];
  end

  logic grant_in_range;
  logic owner_in_range;

  // Only a non-power-of-two master count leaves unused grant encodings.
  if ((1 << MW) == NUM_MASTERS) begin : g_pow2
    assign grant_in_range = 1'b1;
    assign owner_in_range = 1'b1;
  end else begin : g_npow2
    localparam logic [MW-1:0] LAST = MW'(NUM_MASTERS - 1);
    assign grant_in_range = (Hmaster <= LAST);
    assign owner_in_range = (Hmaster_data <= LAST);
  end

  logic          addr_ok;
  logic [MW-1:0] grant_sel;
  logic [MW-1:0] owner_sel;
  logic          data_write;

  assign addr_ok   = !Hreset && grant_in_range;
  assign grant_sel = grant_in_range ? Hmaster : '0;
  assign owner_sel = owner_in_range ? Hmaster_data : '0;

  always_comb begin
    Haddr     = '0;
    Htrans    = 2'b00;
    Hwrite    = 1'b0;
    Hsize     = 3'b000;
    Hburst    = 3'b000;
    Hprot     = 4'b0011;
    Hmastlock = 1'b0;
    if (addr_ok) begin
      Haddr     = addr_a[grant_sel];
      Htrans    = trans_a[grant_sel];
      Hwrite    = Hwrite_M[grant_sel];
      Hsize     = size_a[grant_sel];
      Hburst    = burst_a[grant_sel];
      Hprot     = prot_a[grant_sel];
      Hmastlock = Hmastlock_M[grant_sel];
    end
  end

  // Data-phase owner only advances on accepted address phases.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Hmaster_data <= '0;
      Hdata_active <= 1'b0;
      data_write   <= 1'b0;
    end else if (Hready) begin
      Hmaster_data <= Hmaster;
      Hdata_active <= Htrans[1];
      data_write   <= Hwrite;
    end
  end

  always_comb begin
    Hwdata = '0;
    if (Hdata_active && data_write && owner_in_range)
      Hwdata = wdata_a[owner_sel];
  end

endmodule

// File: tb/tb_ahb_master_mux_pipelined.sv
// Bench for ahb_master_mux_pipelined: a 4-master and a 3-master instance share
// stimulus and are compared every cycle against a transfer-level model.
module tb_ahb_master_mux_pipelined;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic [1:0]   hm;
  logic [127:0] addr_m;
  logic [7:0]   trans_m;
  logic [3:0]   write_m;
  logic [11:0]  size_m;
  logic [11:0]  burst_m;
  logic [15:0]  prot_m;
  logic [3:0]   lock_m;
  logic [127:0] wdata_m;

  logic [31:0] haddr_o  [2];
  logic [1:0]  htrans_o [2];
  logic        hwrite_o [2];
  logic [2:0]  hsize_o  [2];
  logic [2:0]  hburst_o [2];
  logic [3:0]  hprot_o  [2];
  logic        hlock_o  [2];
  logic [31:0] hwdata_o [2];
  logic [1:0]  hmd_o    [2];
  logic        hact_o   [2];

  int checks = 0;
  int errors = 0;

  // Data phase as seen by the model: which master's transfer is in flight.
  int m_owner  [2];
  bit m_active [2];
  bit m_write  [2];
  int nm_of    [2] = '{4, 3};

  always #5 clk = ~clk;

  ahb_master_mux_pipelined #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .Hclk(clk), .Hreset(rst), .Hmaster(hm), .Hready(ready),
    .Haddr_M(addr_m), .Htrans_M(trans_m), .Hwrite_M(write_m),
    .Hsize_M(size_m), .Hburst_M(burst_m), .Hprot_M(prot_m),
    .Hmastlock_M(lock_m), .Hwdata_M(wdata_m),
    .Haddr(haddr_o[0]), .Htrans(htrans_o[0]), .Hwrite(hwrite_o[0]),
    .Hsize(hsize_o[0]), .Hburst(hburst_o[0]), .Hprot(hprot_o[0]),
    .Hmastlock(hlock_o[0]), .Hwdata(hwdata_o[0]),
    .Hmaster_data(hmd_o[0]), .Hdata_active(hact_o[0])
  );

  ahb_master_mux_pipelined #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .Hclk(clk), .Hreset(rst), .Hmaster(hm), .Hready(ready),
    .Haddr_M(addr_m[95:0]), .Htrans_M(trans_m[5:0]), .Hwrite_M(write_m[2:0]),
    .Hsize_M(size_m[8:0]), .Hburst_M(burst_m[8:0]), .Hprot_M(prot_m[11:0]),
    .Hmastlock_M(lock_m[2:0]), .Hwdata_M(wdata_m[95:0]),
    .Haddr(haddr_o[1]), .Htrans(htrans_o[1]), .Hwrite(hwrite_o[1]),
    .Hsize(hsize_o[1]), .Hburst(hburst_o[1]), .Hprot(hprot_o[1]),
    .Hmastlock(hlock_o[1]), .Hwdata(hwdata_o[1]),
    .Hmaster_data(hmd_o[1]), .Hdata_active(hact_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input int k);
    return !rst && (int'(hm) < nm_of[k]);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit ok = addr_ok(k);
      int s  = int'(hm);
      logic [12:0] ctl_exp;
      logic [31:0] wd_exp;
      ctl_exp = ok ? {write_m[s], size_m[s*3 +: 3], burst_m[s*3 +: 3], prot_m[s*4 +: 4], lock_m[s]}
                   : {1'b0, 3'b000, 3'b000, 4'b0011, 1'b0};
      wd_exp  = (m_active[k] && m_write[k]) ? wdata_m[m_owner[k]*32 +: 32] : 32'h0;
      chk($sformatf("htrans%0d", k), htrans_o[k], ok ? trans_m[s*2 +: 2] : 2'b00);
      chk($sformatf("haddr%0d", k), haddr_o[k], ok ? addr_m[s*32 +: 32] : 32'h0);
      chk($sformatf("ctl%0d", k),
          {hwrite_o[k], hsize_o[k], hburst_o[k], hprot_o[k], hlock_o[k]}, ctl_exp);
      chk($sformatf("hwdata%0d", k), hwdata_o[k], wd_exp);
      chk($sformatf("hmaster_data%0d", k), hmd_o[k], m_owner[k]);
      chk($sformatf("hdata_active%0d", k), hact_o[k], m_active[k]);
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = 0; m_active[k] = 0; m_write[k] = 0;
      end else if (ready) begin
        m_owner[k]  = int'(hm);
        m_active[k] = addr_ok(k) && trans_m[int'(hm)*2 + 1];
        m_write[k]  = addr_ok(k) && write_m[int'(hm)];
      end
    end
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [2:0] b);
    trans_m[m*2 +: 2]  = t;
    write_m[m]         = w;
    addr_m[m*32 +: 32] = a;
    burst_m[m*3 +: 3]  = b;
    size_m[m*3 +: 3]   = 3'b010;
    prot_m[m*4 +: 4]   = 4'b0011;
    lock_m[m]          = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_active[k] = 0; m_write[k] = 0;
    end
    rst = 1'b1; ready = 1'b1; hm = 2'd0;
    addr_m = '0; trans_m = '0; write_m = '0; size_m = '0; burst_m = '0;
    prot_m = '0; lock_m = 4'hF; wdata_m = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) set_m(i, 2'b10, 1'b1, 32'(i * 16 + 8), 3'b000);
    lock_m = 4'hF;
    @(negedge clk);

    // Reset with every master requesting a locked NONSEQ write
    settle(); tick();
    settle();
    chk("rst_htrans", htrans_o[0], 2'b00);
    chk("rst_hmastlock", hlock_o[0], 1'b0);
    chk("rst_hwdata", hwdata_o[0], 32'h0);
    chk("rst_hmaster_data", hmd_o[0], 2'd0);
    chk("rst_hdata_active", hact_o[0], 1'b0);
    tick();

    // Single write from master 2
    rst = 1'b0; lock_m = '0;
    for (int i = 0; i < 4; i++) set_m(i, 2'b00, 1'b0, 32'h0, 3'b000);
    hm = 2'd2; set_m(2, 2'b10, 1'b1, 32'h1000, 3'b000);
    settle();
    chk("sw_haddr", haddr_o[0], 32'h1000);
    tick();
    set_m(2, 2'b00, 1'b0, 32'h0, 3'b000);
    wdata_m[2*32 +: 32] = 32'hCAFEF00D;
    settle();
    chk("sw_hwdata", hwdata_o[0], 32'hCAFEF00D);
    chk("sw_hmaster_data", hmd_o[0], 2'd2);
    chk("sw_hdata_active", hact_o[0], 1'b1);
    tick();

    // Handover: master 1 write, then master 3 read
    hm = 2'd1; set_m(1, 2'b10, 1'b1, 32'h20, 3'b000);
    settle(); tick();
    hm = 2'd3; set_m(1, 2'b00, 1'b0, 32'h0, 3'b000);
    set_m(3, 2'b10, 1'b0, 32'h40, 3'b000);
    v = $urandom; wdata_m[1*32 +: 32] = v;
    settle();
    chk("ho_haddr", haddr_o[0], 32'h40);
    chk("ho_hwdata_old", hwdata_o[0], v);
    chk("oor_htrans", htrans_o[1], 2'b00);
    chk("oor_hprot", hprot_o[1], 4'b0011);
    tick();
    set_m(3, 2'b00, 1'b0, 32'h0, 3'b000);
    hm = 2'd0;
    settle();
    chk("ho_hwdata_read", hwdata_o[0], 32'h0);
    chk("ho_hmaster_data", hmd_o[0], 2'd3);
    chk("oor_hdata_active", hact_o[1], 1'b0);
    chk("oor_hwdata", hwdata_o[1], 32'h0);
    tick();

    // Wait states while the grant moves from master 0 to master 1
    hm = 2'd0; set_m(0, 2'b10, 1'b1, 32'h80, 3'b000);
    settle(); tick();
    ready = 1'b0; hm = 2'd1;
    set_m(0, 2'b00, 1'b0, 32'h0, 3'b000);
    set_m(1, 2'b10, 1'b0, 32'h90, 3'b000);
    for (int c = 0; c < 3; c++) begin
      v = $urandom; wdata_m[0 +: 32] = v;
      settle();
      chk("ws_hmaster_data", hmd_o[0], 2'd0);
      chk("ws_hwdata", hwdata_o[0], v);
      tick();
    end
    ready = 1'b1;
    settle(); tick();
    set_m(1, 2'b00, 1'b0, 32'h0, 3'b000);
    settle();
    chk("ws_release_owner", hmd_o[0], 2'd1);
    tick();

    // INCR4 write from master 1, reset at beat 2
    hm = 2'd1; set_m(1, 2'b10, 1'b1, 32'h100, 3'b011);
    settle(); tick();
    set_m(1, 2'b11, 1'b1, 32'h104, 3'b011);
    rst = 1'b1;
    settle(); tick();
    rst = 1'b0; set_m(1, 2'b00, 1'b0, 32'h0, 3'b000);
    settle();
    chk("rmb_hdata_active", hact_o[0], 1'b0);
    chk("rmb_hwdata", hwdata_o[0], 32'h0);
    tick();
    settle();
    chk("rmb_no_leak", hwdata_o[0], 32'h0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      ready = ($urandom_range(0, 3) != 0);
      hm    = 2'($urandom_range(0, 3));
      addr_m  = {$urandom, $urandom, $urandom, $urandom};
      wdata_m = {$urandom, $urandom, $urandom, $urandom};
      trans_m = 8'($urandom);
      write_m = 4'($urandom);
      size_m  = 12'($urandom);
      burst_m = 12'($urandom);
      prot_m  = 16'($urandom);
      lock_m  = 4'($urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_mux_pipelined.md
Name: ahb_master_mux_pipelined

Overview:
Parametrised AHB-Lite master-to-slave multiplexer for the multi-master interconnect. It sits between the arbiter and the slave decoder. The address/control phase is steered by the arbiter's current grant. Write data is steered by a registered data-phase owner that advances only when Hready is high, so write data stays correctly aligned across bus handover. Out-of-range grants and reset force a safe IDLE bus.

Parameters:
NUM_MASTERS, 4, number of master channels (2..16)
ADDR_W, 32, address width
DATA_W, 32, write-data width
MW, $clog2(NUM_MASTERS), master index width (derived, localparam)

Ports:
Hclk  input  1  bus clock, all state on rising edge
Hreset  input  1  synchronous, active-high reset
Hmaster  input  MW  arbiter grant; selects the address-phase master
Hready  input  1  bus-wide HREADY from the slave response mux
Haddr_M  input  [NUM_MASTERS] x ADDR_W  per-master address
Htrans_M  input  [NUM_MASTERS] x 2  per-master transfer type
Hwrite_M  input  [NUM_MASTERS] x 1  per-master write flag
Hsize_M  input  [NUM_MASTERS] x 3  per-master size
Hburst_M  input  [NUM_MASTERS] x 3  per-master burst
Hprot_M  input  [NUM_MASTERS] x 4  per-master protection
Hmastlock_M  input  [NUM_MASTERS] x 1  per-master lock request
Hwdata_M  input  [NUM_MASTERS] x DATA_W  per-master write data
Haddr  output  ADDR_W  muxed address
Htrans  output  2  muxed transfer type
Hwrite  output  1  muxed write flag
Hsize  output  3  muxed size
Hburst  output  3  muxed burst
Hprot  output  4  muxed protection
Hmastlock  output  1  muxed lock
Hwdata  output  DATA_W  data-phase write data
Hmaster_data  output  MW  registered data-phase owner
Hdata_active  output  1  registered: a NONSEQ/SEQ transfer is in its data phase

Behaviour:
- Address phase (combinational): all address/control outputs equal the Hmaster-indexed input channel.
- Safe-idle override:
  - Condition: Hreset=1, or Hmaster >= NUM_MASTERS (reachable only when NUM_MASTERS is not a power of 2).
  - Outputs forced: Htrans=2'b00 (IDLE), Hmastlock=0, Hwrite=0, Haddr=0, Hsize=0, Hburst=0, Hprot=4'b0011.
- Data-phase registers: Hmaster_data, Hdata_active, and an internal data_write bit.
  - On a rising edge with Hready=1:
    - Hmaster_data <= Hmaster.
    - Hdata_active <= (Htrans[1]==1) after override.
    - data_write <= Hwrite after override.
  - With Hready=0: all three hold their values, so wait states extend the data phase.
- Hwdata (combinational):
  - Equals Hwdata_M[Hmaster_data] when Hdata_active=1 and data_write=1.
  - Otherwise Hwdata=0. This covers reads, IDLE, BUSY, and out-of-range owners.
- Latency: address/control outputs have 0 cycles of latency. Hwdata follows the master that owned the previous accepted address phase, exactly one Hready-qualified cycle later.
- Handover: when Hmaster changes on an edge with Hready=1:
  - The new master drives address/control immediately.
  - The old master continues to drive Hwdata until the next Hready=1 edge.
- Hready=0 coinciding with a Hmaster change:
  - Address/control follow the new Hmaster combinationally. The arbiter must not do this, but the mux does not prevent it.
  - The data-phase owner is unchanged.
- Reset:
  - Hreset=1 on an edge forces Hmaster_data=0, Hdata_active=0 and data_write=0 regardless of Hready.
  - Reset asserted mid-burst aborts the data phase; Hwdata=0 from the following cycle.
- Reset values: Htrans=IDLE, Hmastlock=0, Hwdata=0, Hmaster_data=0, Hdata_active=0.
- BUSY (2'b01) and IDLE do not set Hdata_active.

Test Plan:
- Reset: hold Hreset=1 for 2 cycles with all masters driving NONSEQ -> Htrans=0, Hmastlock=0, Hwdata=0, Hmaster_data=0, Hdata_active=0.
- Single write:
  - Setup: Hmaster=2, Htrans_M[2]=NONSEQ, Hwrite_M[2]=1, Haddr_M[2]=0x1000, Hready=1.
  - Same cycle: Haddr=0x1000.
  - Next cycle, with Hwdata_M[2]=0xCAFEF00D: Hwdata=0xCAFEF00D, Hmaster_data=2, Hdata_active=1.
- Handover:
  - Setup: master 1 write to 0x20; the next edge switches Hmaster to 3, which issues a read from 0x40.
  - Cycle after the switch: Haddr=0x40 and Hwdata=Hwdata_M[1].
  - Following cycle: Hwdata=0 (read data phase), Hmaster_data=3.
- Wait states:
  - Setup: master 0 write accepted, then Hready=0 for 3 cycles while Hmaster changes to 1.
  - During the wait: Hmaster_data stays 0 and Hwdata=Hwdata_M[0] for all 3 cycles.
  - After Hready returns: updates on the first Hready=1 edge.
- Out-of-range grant: NUM_MASTERS=3, Hmaster=3 -> Htrans=IDLE, Hprot=0x3; next cycle Hdata_active=0 and Hwdata=0.
- Reset mid-burst: INCR4 write from master 1, assert Hreset at beat 2 -> Hdata_active=0 and Hwdata=0 on the next cycle; no beat leaks after reset.
